// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4
//   Packet-aware 1-to-4 stream demultiplexer. The destination is taken from
//   in_sel on a packet's first beat and locked until its last beat. Each
//   output owns a one-entry register slot, so outputs are registered and
//   drain independently; a full slot that is being drained can be reloaded
//   in the same cycle, giving one beat per cycle.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   input handshake; in_data/in_last/in_sel beat fields
//   out_valid[i]     slot i holds a beat; out_ready[i] downstream i accepts
//   out_d0..out_d3   slot data; out_last[i] slot i beat ends a packet
//   busy             inside a multi-beat packet
//   cur_sel          locked destination, meaningful only while busy=1
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_d0,
  output logic [W-1:0] out_d1,
  output logic [W-1:0] out_d2,
  output logic [W-1:0] out_d3,
  output logic [3:0]   out_last,
  output logic         busy,
  output logic [1:0]   cur_sel
);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   cur_sel_q, cur_sel_nxt;
  logic [1:0]   route;
  logic         accept;
  logic [3:0]   load;
  logic [W-1:0] slot_d [4];
  logic [3:0]   slot_v;
  logic [3:0]   slot_l;

  // Routing, handshake and next-state logic. in_ready looks only at the
  // routed slot, so a stalled destination blocks the input in order.
  always_comb begin
    route       = (state == IDLE) ? in_sel : cur_sel_q;
    in_ready    = !slot_v[route] || out_ready[route];
    accept      = in_valid && in_ready;
    load        = '0;
    load[route] = accept;
    state_nxt   = state;
    cur_sel_nxt = cur_sel_q;
    if (state == IDLE) begin
      if (accept && !in_last) begin
        state_nxt   = PKT;
        cur_sel_nxt = in_sel;
      end
    end else begin
      if (accept && in_last) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_sel_q <= '0;
    end else begin
      state     <= state_nxt;
      cur_sel_q <= cur_sel_nxt;
    end
  end

  // Load takes priority over drain, so a slot reloaded while draining stays
  // valid. Data is held on a plain drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v <= '0;
      slot_l <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        slot_d[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (load[i]) begin
          slot_d[i] <= in_data;
          slot_l[i] <= in_last;
          slot_v[i] <= 1'b1;
        end else if (slot_v[i] && out_ready[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = slot_v;
  assign out_last  = slot_l;
  assign out_d0    = slot_d[0];
  assign out_d1    = slot_d[1];
  assign out_d2    = slot_d[2];
  assign out_d3    = slot_d[3];
  assign busy      = (state == PKT);
  assign cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Testbench for stream_demux_1_4: directed scenarios plus a randomized soak.
// Expected beats are queued per destination when the input handshake
// completes; a monitor pops and compares whenever an output handshakes.
module tb_stream_demux_1_4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
  logic [3:0]   out_last;
  logic         busy;
  logic [1:0]   cur_sel;

  stream_demux_1_4 #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .out_last(out_last), .busy(busy), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t exp_q [4][$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  soak_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] dout(input int i);
    case (i)
      0: return out_d0;
      1: return out_d1;
      2: return out_d2;
      default: return out_d3;
    endcase
  endfunction

  // Present one beat, wait (bounded) for acceptance, queue it for its packet's
  // destination, and release in_valid just after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic [W-1:0] d, input logic l,
                      input int dest, output int waited);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q[dest].push_back(beat_t'{d: d, l: l});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: a beat leaves slot i at the next edge when
  // out_valid[i] && out_ready[i] is seen here.
  beat_t mon_b;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_beat_out%0d", i), {31'd0, out_valid[i]}, 32'd0);
          end else begin
            mon_b = exp_q[i].pop_front();
            chk($sformatf("sb_data_out%0d", i), {28'd0, dout(i)}, {28'd0, mon_b.d});
            chk($sformatf("sb_last_out%0d", i), {31'd0, out_last[i]}, {31'd0, mon_b.l});
          end
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (soak_en) begin
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(3) != 0);
    end
  end

  // Upstream must hold a refused beat stable.
  assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data) && $stable(in_sel) && $stable(in_last)));

  initial begin
    int w;
    int beats;
    int len;
    logic [1:0]   psel, s;
    logic [W-1:0] rd;
    logic         lst;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = '0;
    out_ready = 4'b1111;
    #12;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {28'd0, out_last}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_cur_sel",   {30'd0, cur_sel}, 32'd0);
    chk("rst_out_d",     {16'd0, out_d3, out_d2, out_d1, out_d0}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Reset in the middle of a packet.
    send(2'd2, 4'hA, 1'b0, 2, w);
    send(2'd2, 4'hB, 1'b0, 2, w);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    send(2'd1, 4'h5, 1'b1, 1, w);
    chk("postrst_valid", {28'd0, out_valid}, 32'b0010);
    chk("postrst_d1", {28'd0, out_d1}, 32'h5);

    // Single-beat routing, back to back.
    for (int k = 0; k < 4; k++) begin
      send(k[1:0], W'(k + 1), 1'b1, k, w);
      chk($sformatf("single_valid%0d", k), {31'd0, out_valid[k]}, 32'd1);
      chk($sformatf("single_data%0d", k), {28'd0, dout(k)}, k + 1);
      chk($sformatf("single_last%0d", k), {31'd0, out_last[k]}, 32'd1);
      chk($sformatf("single_wait%0d", k), w, 32'd0);
      chk($sformatf("single_busy%0d", k), {31'd0, busy}, 32'd0);
    end

    // Destination locks on the first beat.
    send(2'd1, 4'hA, 1'b0, 1, w);
    chk("lock_busy1", {31'd0, busy}, 32'd1);
    chk("lock_cur1", {30'd0, cur_sel}, 32'd1);
    chk("lock_valid1", {28'd0, out_valid}, 32'b0010);
    send(2'd3, 4'hB, 1'b0, 1, w);
    chk("lock_busy2", {31'd0, busy}, 32'd1);
    chk("lock_cur2", {30'd0, cur_sel}, 32'd1);
    chk("lock_valid2", {28'd0, out_valid}, 32'b0010);
    send(2'd0, 4'hC, 1'b0, 1, w);
    chk("lock_busy3", {31'd0, busy}, 32'd1);
    chk("lock_valid3", {28'd0, out_valid}, 32'b0010);
    send(2'd2, 4'hD, 1'b1, 1, w);
    chk("lock_busy4", {31'd0, busy}, 32'd0);
    chk("lock_d4", {28'd0, out_d1}, 32'hD);
    chk("lock_last4", {31'd0, out_last[1]}, 32'd1);
    chk("lock_valid4", {28'd0, out_valid}, 32'b0010);

    // Back-pressure on slot 2, then same-cycle drain and reload.
    out_ready = 4'b1011;
    send(2'd2, 4'h7, 1'b1, 2, w);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h9; in_last = 1'b1;
    #1;
    chk("bp_ready0", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("bp_hold_d2", {28'd0, out_d2}, 32'h7);
    chk("bp_ready1", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 4'b1111;
    @(negedge clk);
    chk("bp_ready2", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q[2].push_back(beat_t'{d: 4'h9, l: 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid2", {31'd0, out_valid[2]}, 32'd1);
    chk("bp_d2", {28'd0, out_d2}, 32'h9);

    // A stalled slot 0 does not block traffic to slot 1.
    @(posedge clk); #1;
    out_ready = 4'b1110;
    send(2'd0, 4'h3, 1'b1, 0, w);
    send(2'd1, 4'h6, 1'b1, 1, w);
    chk("indep_wait", w, 32'd0);
    chk("indep_d1", {28'd0, out_d1}, 32'h6);
    chk("indep_v0", {31'd0, out_valid[0]}, 32'd1);
    chk("indep_d0", {28'd0, out_d0}, 32'h3);
    out_ready = 4'b1111;

    // Random soak: packets of 1-8 beats, noise on in_sel after the first beat.
    soak_en = 1'b1;
    beats = 0;
    while (beats < 10000) begin
      len  = $urandom_range(8, 1);
      psel = 2'($urandom_range(3));
      for (int k = 0; k < len && beats < 10000; k++) begin
        s   = (k == 0) ? psel : 2'($urandom_range(3));
        rd  = W'($urandom);
        lst = (k == len - 1) || (beats == 9999);
        send(s, rd, lst, psel, w);
        beats++;
        if ($urandom_range(3) == 0) begin
          in_sel = 2'($urandom_range(3));
          @(posedge clk); #1;
        end
      end
    end
    soak_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 4'b1111;
    repeat (5) @(posedge clk);
    #1;
    chk("soak_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_empty%0d", i), exp_q[i].size(), 32'd0);
    end
    chk("drain_valid", {28'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
